// File: rtl/dcm_pkg.sv
// ----------------------------------------------------------------------------
// dcm_pkg
// Shared definitions for the programmable clock generator and its mode
// controller: mode width, the top mode value and the controller FSM states.
// ----------------------------------------------------------------------------
package dcm_pkg;

   localparam int               PROG_W   = 3;
   localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CONFIRM = 2'd2
   } state_t;

endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// ----------------------------------------------------------------------------
// dcm_prog_ctrl_if
// Programming link between the mode controller and the clock generator.
//   update   : one-cycle pulse asking the generator to latch prog_sel
//   prog_sel : mode presented to the generator's prog_in
//   prog_fb  : generator's prog_out, the mode it is actually running
// master = controller side, slave = generator side.
// ----------------------------------------------------------------------------
interface dcm_prog_ctrl_if;
   import dcm_pkg::*;

   logic              update;
   logic [PROG_W-1:0] prog_sel;
   logic [PROG_W-1:0] prog_fb;

   modport master (output update, output prog_sel, input prog_fb);
   modport slave  (input update, input prog_sel, output prog_fb);

endinterface

// File: rtl/ctrl_edge_det.sv
// ----------------------------------------------------------------------------
// ctrl_edge_det
// Rising-edge detector for a synchronous level.
//   clock : system clock
//   reset : asynchronous, active-low
//   din   : level input
//   rise  : high for the cycle in which din is 1 and was 0 at the last edge
// The history flop resets to 1 so a level already high when reset is
// released is not seen as a new event.
// ----------------------------------------------------------------------------
module ctrl_edge_det (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic prev;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) prev <= 1'b1;
      else        prev <= din;
   end

   assign rise = din & ~prev;

endmodule

// File: rtl/dcm_prog_ctrl.sv
// ----------------------------------------------------------------------------
// dcm_prog_ctrl
// Selects the divider mode of the programmable clock generator. Button,
// load and auto-sweep events become single update pulses; each change is
// confirmed against the generator feedback, re-issued on timeout and flagged
// in err when it keeps failing.
//   clock, reset      : system clock, asynchronous active-low reset
//   btn_up / btn_down : rising edge requests mode +1 / -1 (saturating)
//   load, load_val    : rising edge requests mode = load_val
//   auto_en, tick_in  : auto-sweep enable and the generator's slow tick
//   gen               : update / prog_sel / prog_fb link to the generator
//   cur_prog          : last confirmed mode
//   busy              : request in flight
//   err               : sticky confirm-failure flag
// ----------------------------------------------------------------------------
module dcm_prog_ctrl
   import dcm_pkg::*;
#(
   parameter int AUTO_TICKS      = 8,
   parameter int CONFIRM_TIMEOUT = 4,
   parameter int MAX_RETRY       = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              load,
   input  logic [PROG_W-1:0] load_val,
   input  logic              auto_en,
   input  logic              tick_in,
   dcm_prog_ctrl_if.master   gen,
   output logic [PROG_W-1:0] cur_prog,
   output logic              busy,
   output logic              err
);

   localparam logic [7:0] AUTO_LAST = 8'(AUTO_TICKS - 1);
   localparam logic [3:0] TMO_LAST  = 4'(CONFIRM_TIMEOUT - 1);
   localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

   function automatic logic [PROG_W-1:0] sat_inc(input logic [PROG_W-1:0] v);
      return (v == PROG_MAX) ? v : v + 3'd1;
   endfunction

   function automatic logic [PROG_W-1:0] sat_dec(input logic [PROG_W-1:0] v);
      return (v == '0) ? v : v - 3'd1;
   endfunction

   logic up_ev, dn_ev, ld_ev, tk_ev;

   ctrl_edge_det u_ed_up   (.clock(clock), .reset(reset), .din(btn_up),   .rise(up_ev));
   ctrl_edge_det u_ed_down (.clock(clock), .reset(reset), .din(btn_down), .rise(dn_ev));
   ctrl_edge_det u_ed_load (.clock(clock), .reset(reset), .din(load),     .rise(ld_ev));
   ctrl_edge_det u_ed_tick (.clock(clock), .reset(reset), .din(tick_in),  .rise(tk_ev));

   state_t            state_q, state_d;
   logic [PROG_W-1:0] prog_sel_q, prog_sel_d;
   logic [PROG_W-1:0] cur_q, cur_d;
   logic              err_q, err_d;
   logic              upd_q, busy_q;
   logic [1:0]        retry_q, retry_d;
   logic [3:0]        timer_q, timer_d;
   logic              from_load_q, from_load_d;
   logic [7:0]        auto_cnt_q;
   logic              auto_pend_q;
   logic              auto_take;
   logic              req_vld, req_load;
   logic [PROG_W-1:0] target;

   // Auto-sweep: counts ticks in every state; a pending step waits for IDLE.
   // A new step reached in the same cycle as the old one is taken wins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         auto_cnt_q  <= '0;
         auto_pend_q <= 1'b0;
      end else if (!auto_en) begin
         auto_cnt_q  <= '0;
         auto_pend_q <= 1'b0;
      end else begin
         if (tk_ev && auto_cnt_q == AUTO_LAST) begin
            auto_cnt_q  <= '0;
            auto_pend_q <= 1'b1;
         end else begin
            if (tk_ev) auto_cnt_q <= auto_cnt_q + 8'd1;
            if (auto_take) auto_pend_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      prog_sel_d  = prog_sel_q;
      cur_d       = cur_q;
      err_d       = err_q;
      retry_d     = retry_q;
      timer_d     = timer_q;
      from_load_d = from_load_q;
      auto_take   = 1'b0;
      req_vld     = 1'b0;
      req_load    = 1'b0;
      target      = cur_q;
      case (state_q)
         ST_IDLE: begin
            if (ld_ev) begin
               target   = load_val;
               req_vld  = 1'b1;
               req_load = 1'b1;
            end else if (up_ev) begin
               target  = sat_inc(cur_q);
               req_vld = 1'b1;
            end else if (dn_ev) begin
               target  = sat_dec(cur_q);
               req_vld = 1'b1;
            end else if (auto_pend_q) begin
               target    = cur_q + 3'd1;
               req_vld   = 1'b1;
               auto_take = 1'b1;
            end
            // Re-loading the running mode is how an operator acknowledges err.
            if (req_load && target == cur_q) err_d = 1'b0;
            if (req_vld && target != cur_q) begin
               prog_sel_d  = target;
               retry_d     = '0;
               from_load_d = req_load;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_CONFIRM;
         end
         ST_CONFIRM: begin
            if (gen.prog_fb == prog_sel_q) begin
               cur_d = prog_sel_q;
               if (from_load_q) err_d = 1'b0;
               state_d = ST_IDLE;
            end else if (timer_q == TMO_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 2'd1;
                  state_d = ST_ISSUE;
               end else begin
                  // Give up and track whatever the generator is really running.
                  err_d   = 1'b1;
                  cur_d   = gen.prog_fb;
                  state_d = ST_IDLE;
               end
            end else begin
               timer_d = timer_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // update/busy are flops decoded from the next state so they are glitch-free
   // and line up exactly with the ISSUE / ISSUE+CONFIRM cycles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prog_sel_q  <= '0;
         cur_q       <= '0;
         err_q       <= 1'b0;
         retry_q     <= '0;
         timer_q     <= '0;
         from_load_q <= 1'b0;
         upd_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         prog_sel_q  <= prog_sel_d;
         cur_q       <= cur_d;
         err_q       <= err_d;
         retry_q     <= retry_d;
         timer_q     <= timer_d;
         from_load_q <= from_load_d;
         upd_q       <= (state_d == ST_ISSUE);
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign gen.update   = upd_q;
   assign gen.prog_sel = prog_sel_q;
   assign cur_prog     = cur_q;
   assign busy         = busy_q;
   assign err          = err_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dcm_prog_ctrl
// Bench for dcm_prog_ctrl with a simple clock-generator feedback model that
// can be told to ignore update, and a request-level model of the expected
// mode, err flag and update pulses.
// ----------------------------------------------------------------------------
module tb_dcm_prog_ctrl;
   import dcm_pkg::*;

   localparam int AUTO_TICKS      = 2;
   localparam int CONFIRM_TIMEOUT = 4;
   localparam int MAX_RETRY       = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              btn_up, btn_down, load, auto_en, tick_in;
   logic [PROG_W-1:0] load_val;
   logic [PROG_W-1:0] cur_prog;
   logic              busy, err;

   dcm_prog_ctrl_if gif ();

   dcm_prog_ctrl #(
      .AUTO_TICKS(AUTO_TICKS), .CONFIRM_TIMEOUT(CONFIRM_TIMEOUT), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
      .load(load), .load_val(load_val), .auto_en(auto_en), .tick_in(tick_in),
      .gen(gif), .cur_prog(cur_prog), .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   // Clock generator stand-in: latches prog_sel on update unless gen_ok=0.
   bit                gen_ok;
   logic [PROG_W-1:0] gen_mode;
   always @(posedge clock or negedge reset) begin
      if (!reset)                     gen_mode <= '0;
      else if (gif.update && gen_ok)  gen_mode <= gif.prog_sel;
   end
   assign gif.prog_fb = gen_mode;

   // Update pulse monitor.
   int          cyc = 0;
   int          upd_cnt = 0;
   logic [2:0]  upd_q[$];
   int          upd_t[$];
   logic        upd_prev = 1'b0;
   logic        dbl_upd = 1'b0;
   always @(posedge clock) begin
      cyc <= cyc + 1;
      upd_prev <= gif.update;
      if (gif.update) begin
         upd_cnt <= upd_cnt + 1;
         upd_q.push_back(gif.prog_sel);
         upd_t.push_back(cyc);
      end
      if (gif.update && upd_prev) dbl_upd <= 1'b1;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Request-level model state.
   logic [2:0] m_cur;
   logic       m_err;

   // kind: 0 = load, 1 = up, 2 = down
   function automatic logic [2:0] model_target(input int kind, input logic [2:0] val,
                                               input logic [2:0] cur);
      int t;
      case (kind)
         0:       t = val;
         1:       t = (cur == 7) ? 7 : cur + 1;
         default: t = (cur == 0) ? 0 : cur - 1;
      endcase
      return 3'(t);
   endfunction

   task automatic press(input bit u, input bit d, input bit l);
      @(negedge clock);
      btn_up = u; btn_down = d; load = l;
      @(negedge clock);
      btn_up = 1'b0; btn_down = 1'b0; load = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin
         @(negedge clock);
         n++;
      end
      chk("idle_reached", busy, 0);
      repeat (2) @(negedge clock);
   endtask

   task automatic do_req(input int kind, input logic [2:0] val);
      logic [2:0] tgt;
      int         b;
      b   = upd_cnt;
      tgt = model_target(kind, val, m_cur);
      load_val = val;
      press(kind == 1, kind == 2, kind == 0);
      wait_idle(40);
      if (kind == 0) m_err = 1'b0;
      if (tgt != m_cur) begin
         chk("req_updates", upd_cnt - b, 1);
         chk("req_prog_sel", upd_q[$], tgt);
         m_cur = tgt;
      end else begin
         chk("req_no_update", upd_cnt - b, 0);
      end
      chk("req_cur_prog", cur_prog, m_cur);
      chk("req_err", err, m_err);
   endtask

   // btn_up while the generator ignores update: initial issue plus retries.
   task automatic fail_req();
      int b, qb;
      gen_ok = 1'b0;
      b  = upd_cnt;
      qb = upd_t.size();
      press(1'b1, 1'b0, 1'b0);
      wait_idle(80);
      chk("fail_updates", upd_cnt - b, 1 + MAX_RETRY);
      if (upd_t.size() >= qb + 3) begin
         chk("fail_gap1", upd_t[qb+1] - upd_t[qb],   CONFIRM_TIMEOUT + 1);
         chk("fail_gap2", upd_t[qb+2] - upd_t[qb+1], CONFIRM_TIMEOUT + 1);
      end
      m_err = 1'b1;
      chk("fail_err", err, m_err);
      chk("fail_cur_prog", cur_prog, m_cur);
      gen_ok = 1'b1;
   endtask

   task automatic tick();
      @(negedge clock); tick_in = 1'b1;
      repeat (4) @(negedge clock);
      tick_in = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   initial begin
      int         b, qb, tk;
      logic [2:0] exp_q[$];

      reset = 1'b1; btn_up = 1'b1; btn_down = 1'b0; load = 1'b0; load_val = '0;
      auto_en = 1'b0; tick_in = 1'b0; gen_ok = 1'b1;
      m_cur = '0; m_err = 1'b0;
      #2 reset = 1'b0;

      // Reset state, btn_up held high through release
      repeat (2) @(negedge clock);
      chk("rst_update", gif.update, 0);
      chk("rst_prog_sel", gif.prog_sel, 0);
      chk("rst_cur_prog", cur_prog, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      b = upd_cnt;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("held_no_event", upd_cnt - b, 0);
      chk("held_busy", busy, 0);
      btn_up = 1'b0;
      @(negedge clock); btn_up = 1'b1;
      @(negedge clock); btn_up = 1'b0;
      chk("t1_update_k", gif.update, 1);
      chk("t1_prog_sel", gif.prog_sel, 1);
      chk("t1_busy_k", busy, 1);
      @(negedge clock);
      chk("t1_update_k1", gif.update, 0);
      chk("t1_busy_k1", busy, 1);
      @(negedge clock);
      chk("t1_busy_k2", busy, 0);
      chk("t1_cur_prog", cur_prog, 1);
      m_cur = 3'd1;
      repeat (2) @(negedge clock);

      // Saturation at both ends
      do_req(0, 3'd7);
      do_req(1, 3'd0);
      b = upd_cnt;
      for (int i = 0; i < 8; i++) do_req(2, 3'd0);
      chk("t2_down_updates", upd_cnt - b, 7);
      chk("t2_cur_zero", cur_prog, 0);

      // load beats btn_up; btn_down while busy is dropped
      b = upd_cnt;
      load_val = 3'd4;
      @(negedge clock); load = 1'b1; btn_up = 1'b1;
      @(negedge clock); load = 1'b0; btn_up = 1'b0; btn_down = 1'b1;
      chk("t5_update", gif.update, 1);
      chk("t5_prog_sel", gif.prog_sel, 4);
      @(negedge clock); btn_down = 1'b0;
      wait_idle(40);
      chk("t5_single_update", upd_cnt - b, 1);
      chk("t5_cur_prog", cur_prog, 4);
      m_cur = 3'd4;

      // Random request mix
      for (int i = 0; i < 30; i++)
         do_req(int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)));

      // Auto-sweep from 7, wrapping
      do_req(0, 3'd7);
      b  = upd_cnt;
      qb = upd_q.size();
      tk = 0;
      auto_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         tk++;
         if (tk == AUTO_TICKS) begin
            tk = 0;
            m_cur = m_cur + 3'd1;
            exp_q.push_back(m_cur);
         end
      end
      tick();
      @(negedge clock); auto_en = 1'b0;
      @(negedge clock); auto_en = 1'b1;
      tk = 0;
      tick();
      chk("auto_cleared_no_step", upd_cnt - b, exp_q.size());
      tick();
      m_cur = m_cur + 3'd1;
      exp_q.push_back(m_cur);
      auto_en = 1'b0;
      chk("auto_updates", upd_cnt - b, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (qb + i < upd_q.size()) chk("auto_prog_sel", upd_q[qb+i], exp_q[i]);
      chk("auto_cur_prog", cur_prog, m_cur);

      // Generator ignoring update: retries then err; load clears err
      do_req(0, 3'd0);
      fail_req();
      do_req(0, 3'd5);
      fail_req();
      do_req(0, 3'd5);
      fail_req();

      // Reset in CONFIRM, then in ISSUE: outputs clear without a clock edge
      @(negedge clock); btn_up = 1'b1;
      @(negedge clock); btn_up = 1'b0;
      chk("t6_issue_update", gif.update, 1);
      @(negedge clock);
      chk("t6_confirm_busy", busy, 1);
      #1 reset = 1'b0;
      #1;
      chk("t6_async_update", gif.update, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_cur_prog", cur_prog, 0);
      chk("t6_async_err", err, 0);
      chk("t6_async_prog_sel", gif.prog_sel, 0);
      @(negedge clock); reset = 1'b1;
      m_cur = '0; m_err = 1'b0;
      @(negedge clock); btn_up = 1'b1;
      @(negedge clock); btn_up = 1'b0;
      chk("t6b_issue_update", gif.update, 1);
      #1 reset = 1'b0;
      #1;
      chk("t6b_async_update", gif.update, 0);
      chk("t6b_async_busy", busy, 0);
      @(negedge clock); reset = 1'b1;
      repeat (2) @(negedge clock);
      do_req(1, 3'd0);

      chk("no_back_to_back_update", dbl_upd, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
